// File: rtl/uart_rx_responder_pkg.sv
// Shared register map, STATUS layout and receiver state encoding for the UART
// receive responder.
package uart_rx_pkg;

  localparam logic [31:0] RXDATA_OFF = 32'h0;
  localparam logic [31:0] STATUS_OFF = 32'h4;
  localparam logic [31:0] CTRL_OFF   = 32'h8;

  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FERR = 3;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

  typedef struct packed {
    logic [3:0] cnt;
    logic       ferr;
    logic       ovr;
    logic       full;
    logic       ne;
  } status_t;

endpackage

// File: rtl/uart_rx_responder_rx_fifo.sv
// Byte FIFO for received characters; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [AW:0] wptr, rptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push, do_pop;

  assign empty = (wptr == rptr);
  assign full  = ({~wptr[AW], wptr[AW-1:0]} == rptr);
  assign count = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];

  // a pop frees the slot this edge, so a full FIFO still accepts a push
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_responder.sv
// 8N1 UART receiver at 16x oversampling with a byte FIFO, exposed to the CPU
// data bus as RXDATA / STATUS / CTRL registers plus a level interrupt.
module uart_rx_responder
  import uart_rx_pkg::*;
#(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          BAUD       = 9600,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0020
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  input  logic        UART_RX
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic            rx_meta, rx_sync;
  logic [DW-1:0]   div_cnt;
  logic            tick, start_det;
  rx_state_t       state, state_n;
  logic [3:0]      tick_cnt, tick_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            push_req, ferr_set;
  logic            sel_rx, sel_st, sel_ctrl, pop_req, ovr_set;
  logic            ovr, ferr, irqen;
  logic [7:0]      head;
  logic [AW:0]     fifo_cnt;
  logic            full, empty;
  status_t         st;
  logic            unused_wdata;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
    end
  end

  // Restarting the divider on the start edge phase-locks ticks to the frame
  assign start_det = (state == IDLE) & ~rx_sync;
  assign tick      = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge sysclk) begin
    if (reset)                  div_cnt <= '0;
    else if (start_det || tick) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
    end
  end

  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_idx;
    shreg_n  = shreg;
    push_req = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: if (!rx_sync) begin
        state_n = START;
        tick_n  = '0;
        bit_n   = '0;
      end
      START: if (tick) begin
        tick_n = tick_cnt + 4'd1;
        if (tick_cnt == 4'd7) begin
          tick_n  = '0;
          state_n = rx_sync ? IDLE : DATA;
        end
      end
      DATA: if (tick) begin
        tick_n = tick_cnt + 4'd1;
        if (tick_cnt == 4'd15) begin
          shreg_n = {rx_sync, shreg[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: if (tick) begin
        tick_n = tick_cnt + 4'd1;
        if (tick_cnt == 4'd15) begin
          if (rx_sync) begin
            push_req = 1'b1;
            state_n  = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end
      end
      // hold off until the line idles so a break yields a single error
      WAIT_HIGH: if (rx_sync) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign sel_rx   = (addr == BASE_ADDR + RXDATA_OFF);
  assign sel_st   = (addr == BASE_ADDR + STATUS_OFF);
  assign sel_ctrl = (addr == BASE_ADDR + CTRL_OFF);
  assign pop_req  = rd & sel_rx;
  assign ovr_set  = push_req & full & ~pop_req;

  rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (push_req),
    .pop    (pop_req),
    .wdata  (shreg_n),
    .head   (head),
    .count  (fifo_cnt),
    .full   (full),
    .empty  (empty)
  );

  // set takes priority over a same-edge write-1-clear
  always_ff @(posedge sysclk) begin
    if (reset) begin
      ovr   <= 1'b0;
      ferr  <= 1'b0;
      irqen <= 1'b0;
    end else begin
      if (wr && sel_st) begin
        if (wdata[ST_OVR])  ovr  <= 1'b0;
        if (wdata[ST_FERR]) ferr <= 1'b0;
      end
      if (ovr_set)  ovr  <= 1'b1;
      if (ferr_set) ferr <= 1'b1;
      if (wr && sel_ctrl) irqen <= wdata[0];
    end
  end

  assign st.cnt  = 4'(fifo_cnt);
  assign st.ferr = ferr;
  assign st.ovr  = ovr;
  assign st.full = full;
  assign st.ne   = ~empty;

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rx)        rdata = {24'b0, empty ? 8'h00 : head};
      else if (sel_st)   rdata = {24'b0, st};
      else if (sel_ctrl) rdata = {31'b0, irqen};
    end
  end

  assign irqout       = irqen & ~empty;
  assign unused_wdata = ^{wdata[31:4], wdata[1]};

endmodule

// File: tb/tb_uart_rx_responder.sv
// Randomised and directed bench for uart_rx_responder against a queue-based
// model of the receive FIFO, sticky flags and interrupt enable.
module tb_uart_rx_responder;

  localparam int          FIFO_DEPTH = 4;
  localparam int          BIT        = 160;
  localparam logic [31:0] BASE       = 32'h4000_0020;
  localparam logic [31:0] A_RX       = BASE;
  localparam logic [31:0] A_ST       = BASE + 32'd4;
  localparam logic [31:0] A_CT       = BASE + 32'd8;

  logic        sysclk, reset, rd, wr, irqout, UART_RX;
  logic [31:0] addr, wdata, rdata;

  uart_rx_responder #(
    .CLK_FREQ(1_600_000), .BAUD(10_000), .FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irqout(irqout), .UART_RX(UART_RX)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int         n_chk = 0, n_pass = 0;
  logic [7:0] m_q[$];
  bit         m_ovr = 0, m_ferr = 0, m_irqen = 0, settled = 0;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0] s;
    if (a == A_RX) return (m_q.size() != 0) ? {24'b0, m_q[0]} : 32'b0;
    if (a == A_ST) begin
      s = {4'(m_q.size()), m_ferr, m_ovr, m_q.size() == FIFO_DEPTH, m_q.size() != 0};
      return {24'b0, s};
    end
    if (a == A_CT) return {31'b0, m_irqen};
    return 32'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // cycle-by-cycle comparison whenever the line is quiet
  always @(negedge sysclk) begin
    if (!reset && settled) begin
      chk("irqout", {31'b0, irqout}, {31'b0, (m_irqen && m_q.size() != 0)});
      if (rd) chk("rdata", rdata, m_read(addr));
    end
  end

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    @(negedge sysclk); d = rdata;
    @(posedge sysclk); #1;
    rd = 1'b0; addr = '0;
    if (a == A_RX && m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge sysclk); #1;
    wr = 1'b0; addr = '0; wdata = '0;
    if (a == A_ST) begin
      if (d[2]) m_ovr = 0;
      if (d[3]) m_ferr = 0;
    end
    if (a == A_CT) m_irqen = d[0];
  endtask

  // a stop bit of 0 leaves the line low; the caller ends the break
  task automatic send_frame(input logic [7:0] b, input bit stop);
    settled = 0;
    @(posedge sysclk); #1 UART_RX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge sysclk);
      #1 UART_RX = b[i];
    end
    repeat (BIT) @(posedge sysclk);
    #1 UART_RX = stop;
    repeat (BIT) @(posedge sysclk);
    #1;
    if (stop) begin
      if (m_q.size() == FIFO_DEPTH) m_ovr = 1;
      else m_q.push_back(b);
      repeat (20) @(posedge sysclk);
      #1 settled = 1;
    end else begin
      m_ferr = 1;
    end
  endtask

  task automatic end_break();
    UART_RX = 1'b1;
    repeat (20) @(posedge sysclk);
    #1 settled = 1;
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] ra;
    int          p, frames;
    bit          stp;

    reset = 1; rd = 0; wr = 0; addr = '0; wdata = '0; UART_RX = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq", {31'b0, irqout}, 32'h0);
    reset = 0;
    @(posedge sysclk); #1 settled = 1;
    bus_read(A_ST, d); chk("idle_status", d, 32'h0);
    bus_read(A_RX, d); chk("idle_rxdata", d, 32'h0);
    bus_read(A_CT, d); chk("idle_ctrl", d, 32'h0);

    send_frame(8'hA5, 1);
    bus_write(A_CT, 32'h1);
    bus_read(A_ST, d); chk("a5_status", d, 32'h11);
    chk("a5_irq", {31'b0, irqout}, 32'h1);
    bus_read(A_RX, d); chk("a5_data", d, 32'hA5);
    bus_read(A_ST, d); chk("a5_status_after", d, 32'h0);
    chk("a5_irq_after", {31'b0, irqout}, 32'h0);

    settled = 0;
    @(posedge sysclk); #1 UART_RX = 1'b0;
    repeat (40) @(posedge sysclk);
    #1 UART_RX = 1'b1;
    repeat (200) @(posedge sysclk);
    #1 settled = 1;
    bus_read(A_ST, d); chk("glitch_status", d, 32'h0);

    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1);
    bus_read(A_ST, d); chk("ovr_status", d, 32'h47);
    for (int b = 1; b <= 4; b++) begin
      bus_read(A_RX, d); chk("ovr_data", d, 32'(b));
    end
    bus_write(A_ST, 32'h4);
    bus_read(A_ST, d); chk("ovr_cleared", d, 32'h0);

    send_frame(8'h3C, 0);
    repeat (2000) @(posedge sysclk);
    #1;
    bus_read(A_ST, d); chk("break_status", d, 32'h08);
    end_break();
    send_frame(8'h7E, 1);
    bus_read(A_ST, d); chk("after_break_status", d, 32'h19);
    bus_read(A_RX, d); chk("after_break_data", d, 32'h7E);
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, d); chk("ferr_cleared", d, 32'h0);

    // locate the push edge relative to the start edge, ~9.5 bit times
    p = -1;
    fork
      send_frame(8'h5A, 1);
      begin
        @(posedge sysclk); #1;
        rd = 1'b1; addr = A_ST;
        for (int n = 1; n <= 2000; n++) begin
          @(negedge sysclk);
          if (rdata[7:4] != 4'd0) begin p = n - 1; break; end
        end
        rd = 1'b0; addr = '0;
      end
    join
    n_chk++;
    if (p >= 1510 && p <= 1540) n_pass++;
    else $display("FAIL push_offset: got %0d cycles, expected 1510..1540", p);

    send_frame(8'h11, 1);
    send_frame(8'h22, 1);
    send_frame(8'h33, 1);
    fork
      send_frame(8'h44, 1);
      begin
        @(posedge sysclk);
        if (p > 1) begin
          repeat (p - 1) @(posedge sysclk);
          #1 rd = 1'b1; addr = A_RX;
          @(negedge sysclk) d = rdata;
          @(posedge sysclk);
          #1 rd = 1'b0; addr = '0;
          chk("edge_pop_data", d, 32'h5A);
          void'(m_q.pop_front());
        end
      end
    join
    bus_read(A_ST, d); chk("edge_status", d, 32'h43);
    for (int i = 0; i < 4; i++) begin
      bus_read(A_RX, d); chk("edge_tail", d, 32'h11 * (i + 1));
    end

    frames = 0;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 7))
        0, 1: begin
          case ($urandom_range(0, 6))
            0: ra = A_RX; 1: ra = A_RX; 2: ra = A_ST; 3: ra = A_CT;
            4: ra = BASE + 32'd12; 5: ra = BASE + 32'd1; default: ra = $urandom;
          endcase
          bus_read(ra, d);
        end
        2: bus_write(A_CT, $urandom);
        3: bus_write(A_ST, $urandom);
        4: bus_write(($urandom_range(0, 1) == 0) ? BASE + 32'd16 : $urandom, $urandom);
        default: if (frames < 8) begin
          frames++;
          stp = ($urandom_range(0, 5) != 0);
          send_frame(8'($urandom), stp);
          if (!stp) end_break();
        end
      endcase
      ra = 32'($urandom_range(0, 3));
      if (ra != 0) begin
        repeat (ra) @(posedge sysclk);
        #1;
      end
    end
    while (m_q.size() != 0) bus_read(A_RX, d);
    bus_write(A_ST, 32'hC);
    bus_read(A_ST, d); chk("final_status", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_responder.md
# uart_rx_responder

Memory-mapped UART receiver that answers the CPU data bus as a responder, the counterpart to the pipeline CPU's load/store initiator port. It deserialises 8N1 frames from `UART_RX` at 16x oversampling and buffers bytes in a small FIFO. It exposes data, status and control registers, and raises `irqout` while data is waiting. It sits beside the existing peripheral block on the shared `addr`/`rd`/`wr` bus.

## Interface
- `CLK_FREQ`, 50_000_000, `sysclk` frequency in Hz
- `BAUD`, 9600, line rate
- `FIFO_DEPTH`, 4, receive FIFO entries (power of two, ≥2)
- `BASE_ADDR`, 32'h4000_0020, register block base (word aligned)

Ports:
- `sysclk` in 1: the single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high; clears all state
- `rd` in 1: bus read strobe, one cycle per load
- `wr` in 1: bus write strobe, one cycle per store
- `addr` in 32: byte address
- `wdata` in 32: write data
- `rdata` out 32: read data, combinational
- `irqout` out 1: interrupt request, level
- `UART_RX` in 1: serial input, idle high, asynchronous

## Operation
- Tick divider: `DIV = CLK_FREQ/(BAUD*16)`, integer truncated; default gives 325.
  - Counter 0..DIV-1 produces a one-cycle `tick`.
  - The counter is free-running in IDLE and restarts on start detection.
- `UART_RX` passes through a 2-FF synchroniser, reset value 1.
- Receive FSM (8 data bits):
  - IDLE: synchronised line is 0 → START, tick count = 0.
  - START: after 8 ticks, sample. 0 → DATA; 1 (glitch) → IDLE.
  - DATA: every 16 ticks, sample the next bit, LSB first. After bit 7 → STOP.
  - STOP: after 16 ticks, sample.
    - Sample 1: push the byte. If the FIFO is full, set `OVR` and drop the byte. → IDLE.
    - Sample 0: set `FERR` and discard the byte. → WAIT_HIGH.
  - WAIT_HIGH: synchronised line is 1 → IDLE. This prevents a break from generating repeated frames.
- Registers (address decoded as `addr == BASE_ADDR + off`):
  - +0 RXDATA, read:
    - `rdata = {24'b0, head}`.
    - On that clock edge, the FIFO pops if non-empty.
    - Read while empty returns 0 and does not pop.
  - +4 STATUS, read:
    - bit0 `NE` (not empty)
    - bit1 `FULL`
    - bit2 `OVR`
    - bit3 `FERR`
    - bits 7:4 = occupancy count
    - Write: a 1 in bit2 or bit3 clears that sticky flag.
  - +8 CTRL, read/write: bit0 `IRQEN`.
  - Any other address, or `rd`=0: `rdata = 0`. Writes to other addresses are ignored.
- `irqout = IRQEN & NE`.
- Simultaneous events:
  - Push and pop on the same edge with the FIFO full: both succeed, no `OVR`.
  - Push and pop with the FIFO empty: the pop is a no-op and the push is stored.
  - Flag set and write-1-clear on the same edge: set wins.
- Reset outputs and state:
  - `rdata` = 0, `irqout` = 0.
  - FIFO empty; flags, `IRQEN` and divider cleared; FSM in IDLE.
  - Reset mid-frame abandons the partial byte.

## Timing
- One bit time = 16·DIV cycles.
- Start detection occurs 2 cycles (synchroniser) after the falling edge on `UART_RX`.
- The push occurs at the stop-bit mid-sample, about 9.5 bit times after the start edge. `NE` and `irqout` are visible the cycle after the push edge.
- `rdata` is valid in the same cycle as `rd`. Pointers and `NE` update at the end of that cycle.
- Back-to-back RXDATA reads on consecutive cycles pop consecutive bytes.

## Structure
- Package `uart_rx_pkg` holds:
  - register offsets (`RXDATA_OFF`, `STATUS_OFF`, `CTRL_OFF`)
  - STATUS bit indices
  - FSM state enum `{IDLE, START, DATA, STOP, WAIT_HIGH}`
- Sub-module `rx_fifo`: synchronous FIFO, 8-bit wide, `FIFO_DEPTH` deep, with `push`, `pop`, `head`, `count`, `full` and `empty`. It uses an extra pointer bit for full/empty.
- Top level holds the synchroniser, divider, FSM and register decode.

## Test plan
Benches use `CLK_FREQ=1_600_000`, `BAUD=10_000`, so DIV=10 and a bit is 160 cycles.
- Reset, then idle line: `rdata`=0, `irqout`=0, STATUS=0.
- Send 0xA5, set `IRQEN`:
  - STATUS=0x11, `irqout`=1.
  - RXDATA read → 0xA5, then STATUS=0, `irqout`=0.
- 40-cycle low glitch on `UART_RX`: FSM returns to IDLE, no push, STATUS=0.
- Send 5 bytes 0x01..0x05 without reading:
  - STATUS = FULL|NE|OVR with count 4.
  - Reads return 0x01..0x04. Write 0x4 to STATUS → OVR clear.
- Frame 0x3C with stop bit 0, then line held low 2000 cycles, then a valid 0x7E:
  - FERR=1, no push during the break.
  - 0x7E is received normally.
- FIFO full and a RXDATA read on the exact push edge: no OVR, count stays 4, new byte at tail.
